// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the switch debouncer:
//   - default stability lengths for synthesis and simulation builds
//   - per-bit FSM state type
//   - width helper for the per-bit stability counter
package debounce_pkg;

    // Consecutive stable clocks required before a debounced output flips.
    localparam int SYN_DEBOUNCE_CYCLES = 16;
    localparam int SIM_DEBOUNCE_CYCLES = 4;

    // Per-bit state: STABLE means the synchronised input agrees with the
    // debounced output; PENDING means a disagreement is being timed.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    // Counter must hold 0 .. n-1; $clog2(n+1) covers that with margin and
    // never collapses to zero bits for n == 1.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if
//   Groups the switch-facing and downstream-facing signals of the debouncer.
//   Signals:
//     sw_in    raw asynchronous switch levels
//     sw_out   debounced levels (registered)
//     rise     one-cycle strobe per bit on a 0->1 change of sw_out
//     fall     one-cycle strobe per bit on a 1->0 change of sw_out
//     changed  OR of all rise/fall strobes
//     pending  per-bit FSM state (1 = PENDING), for observation only
//   Handshake: none. sw_in is a free-running level with no valid qualifier and
//   the block never back-pressures; every output is meaningful on every cycle
//   outside reset, with strobes lasting exactly one clock.
//   Modports: master drives sw_in (switch side), slave is the debouncer.
interface switch_debounce_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
    logic [WIDTH-1:0] pending;

    modport master (
        output sw_in,
        input  sw_out,
        input  rise,
        input  fall,
        input  changed,
        input  pending
    );

    modport slave (
        input  sw_in,
        output sw_out,
        output rise,
        output fall,
        output changed,
        output pending
    );
endinterface

// File: rtl/switch_debounce_bit.sv
// debounce_bit
//   One input bit: 2-flop synchroniser, stability counter, two-state FSM,
//   registered debounced level and registered rise/fall strobes.
//   Ports:
//     clk, rst_n  clock and asynchronous active-low reset
//     sw_in       raw asynchronous level
//     sw_out      debounced level
//     rise, fall  one-cycle strobes, high during the first cycle sw_out
//                 shows its new value
//     pending     1 while a disagreement is being timed
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = SYN_DEBOUNCE_CYCLES,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic sw_out,
    output logic rise,
    output logic fall,
    output logic pending
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic          q1, q2;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Synchroniser: only q2 is trusted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= RESET_BIT;
            q2 <= RESET_BIT;
        end else begin
            q1 <= sw_in;
            q2 <= q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            out_q   <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The commit test uses the count *before* this edge: cnt == N-1 means
    // this edge is the N-th consecutive mismatching one. In STABLE the count
    // is 0, so with N == 1 the very first mismatch commits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (q2 != out_q) begin
                    if (cnt_q == CNT_LAST) begin
                        out_d  = q2;
                        cnt_d  = '0;
                        rise_d = q2;
                        fall_d = ~q2;
                    end else begin
                        state_d = ST_PENDING;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_PENDING: begin
                if (q2 == out_q) begin
                    // Bounce returned to the old level: discard silently.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    out_d   = q2;
                    rise_d  = q2;
                    fall_d  = ~q2;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sw_out  = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign pending = (state_q == ST_PENDING);

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce
//   Synchronises and debounces WIDTH raw switch inputs. sw_out[0..2] feed the
//   a, b, c inputs of the downstream boolean stage d = (~a|~b)&~c.
//   Ports:
//     clk    rising-edge system clock
//     rst_n  asynchronous active-low reset
//     bus    switch_debounce_if.slave: sw_in in; sw_out, rise, fall,
//            changed, pending out
//   Parameters:
//     WIDTH            number of independent bits
//     DEBOUNCE_CYCLES  consecutive stable clocks before an output flips (>= 1)
//     RESET_VALUE      reset level for synchronisers and sw_out
module switch_debounce
    import debounce_pkg::*;
#(
    parameter int               WIDTH           = 3,
    parameter int               DEBOUNCE_CYCLES = SYN_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_debounce_if.slave   bus
);

    logic [WIDTH-1:0] out_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] pend_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_in   (bus.sw_in[i]),
            .sw_out  (out_w[i]),
            .rise    (rise_w[i]),
            .fall    (fall_w[i]),
            .pending (pend_w[i])
        );
    end

    assign bus.sw_out  = out_w;
    assign bus.rise    = rise_w;
    assign bus.fall    = fall_w;
    assign bus.pending = pend_w;
    // Pure OR of strobe flops: no path from sw_in.
    assign bus.changed = |(rise_w | fall_w);

endmodule
